// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the ROM boot loader.
//   boot_state_e  : loader FSM state, 3-bit encoding IDLE=0 .. ERR=7
//   ROM_ADDR_W    : instruction ROM address width (32K words)
//   ROM_DEPTH     : instruction ROM depth in words, largest legal image
//   WORD_W/BYTE_W : ROM word width and stream byte width
//   LEN_W         : width of the image length field in the stream header
package boot_pkg;

    localparam int ROM_ADDR_W = 15;
    localparam int ROM_DEPTH  = 32768;
    localparam int WORD_W     = 16;
    localparam int BYTE_W     = 8;
    localparam int LEN_W      = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } boot_state_e;

    // States in which the loader is waiting on the byte stream.
    function automatic logic is_rx_state(boot_state_e s);
        return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
    endfunction

endpackage

// File: rtl/boot_timeout_ctr.sv
// boot_timeout_ctr: idle-cycle counter that flags a stalled byte stream.
//   clk    : system clock
//   rst_n  : synchronous active-low reset, clears the count
//   clr_i  : clear the count to zero (takes priority over en_i)
//   en_i   : count one idle cycle
//   tc_o   : terminal count, high while the count equals TIMEOUT-1
module boot_timeout_ctr #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at TIMEOUT so a counter that is never cleared cannot wrap
    // back through the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/rom_boot_loader.sv
// rom_boot_loader: loads a program image from a byte stream into the
// instruction ROM, holding the CPU in reset until the image is complete.
// Stream format: 16-bit big-endian word count N, then N big-endian words.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : one-cycle pulse that begins a load (ignored while busy)
//   rx_data      : image byte
//   rx_valid     : rx_data is valid
//   rx_ready     : loader accepts a byte this cycle
//   cpu_pc       : CPU fetch address
//   rom_addr     : ROM address, cpu_pc when the CPU runs, else write pointer
//   rom_we       : ROM write strobe
//   rom_wdata    : ROM write data
//   cpu_hold     : high holds the CPU in reset
//   busy         : load in progress
//   done         : image fully written, CPU running
//   error        : load aborted (bad length or stream timeout)
//   dbg_state_o  : current FSM state encoding
//
// Handshake: a byte moves on every rising edge where rx_valid and rx_ready
// are both high. rx_ready is a registered decode of the state and never
// looks at rx_valid; the source may hold rx_valid high indefinitely.
module rom_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DEPTH   = ROM_DEPTH,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_we,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state_o
);

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              rx_ready_q, rom_we_q, cpu_hold_q, busy_q, done_q, error_q;

    logic              xfer;
    logic [LEN_W-1:0]  len_rx;
    logic              len_bad;
    logic              last_word;
    logic              tmo_clr, tmo_en, tmo_tc;

    assign xfer      = rx_valid && rx_ready_q;
    // Full length as it stands once the low byte arrives in LEN_LO.
    assign len_rx    = {len_q[LEN_W-1:BYTE_W], rx_data};
    assign len_bad   = (len_rx == '0) || (32'(len_rx) > 32'(DEPTH));
    assign last_word = (LEN_W'(wr_ptr_q) == (len_q - 1'b1));

    // Counter runs only while waiting on the stream and restarts on every
    // byte and on every state change.
    assign tmo_en  = is_rx_state(state_q) && !xfer;
    assign tmo_clr = xfer || (state_d != state_q);

    boot_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(tmo_clr),
        .en_i (tmo_en),
        .tc_o (tmo_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = LEN_HI;
            LEN_HI: begin
                if (xfer)        state_d = LEN_LO;
                else if (tmo_tc) state_d = ERR;
            end
            LEN_LO: begin
                if (xfer)        state_d = len_bad ? ERR : DATA_HI;
                else if (tmo_tc) state_d = ERR;
            end
            DATA_HI: begin
                if (xfer)        state_d = DATA_LO;
                else if (tmo_tc) state_d = ERR;
            end
            DATA_LO: begin
                if (xfer)        state_d = WRITE;
                else if (tmo_tc) state_d = ERR;
            end
            WRITE:   state_d = last_word ? DONE : DATA_HI;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
            rom_we_q   <= 1'b0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= is_rx_state(state_d);
            rom_we_q   <= (state_d == WRITE);
            cpu_hold_q <= (state_d != DONE);
            busy_q     <= state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE};
            done_q     <= (state_d == DONE);
            error_q    <= (state_d == ERR);

            if (xfer) begin
                case (state_q)
                    LEN_HI:  len_q[LEN_W-1:BYTE_W] <= rx_data;
                    LEN_LO: begin
                        len_q[BYTE_W-1:0] <= rx_data;
                        wr_ptr_q          <= '0;
                    end
                    DATA_HI: wdata_q[WORD_W-1:BYTE_W] <= rx_data;
                    DATA_LO: wdata_q[BYTE_W-1:0]      <= rx_data;
                    default: ;
                endcase
            end

            // Pointer stays on the last address after the final write; N<=DEPTH
            // keeps it from ever wrapping.
            if ((state_q == WRITE) && !last_word) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    assign rx_ready    = rx_ready_q;
    assign rom_we      = rom_we_q;
    assign rom_wdata   = wdata_q;
    assign cpu_hold    = cpu_hold_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign rom_addr    = cpu_hold_q ? wr_ptr_q : cpu_pc;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// tb_rom_boot_loader: directed bench for rom_boot_loader. The ROM is
// shrunk to 4K words so a full-depth image fits a short run; TIMEOUT=16.
module tb_rom_boot_loader;

    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 4096;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] cpu_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_we;
    logic [15:0]       rom_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    rom_boot_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .cpu_pc     (cpu_pc),
        .rom_addr   (rom_addr),
        .rom_we     (rom_we),
        .rom_wdata  (rom_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dbg_state_o(dbg_state)
    );

    // ---------------- ROM model and write log ----------------
    logic [15:0]       rom_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] log_addr[$];
    logic [15:0]       log_data[$];
    logic [15:0]       exp_q[$];

    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            rom_mem[rom_addr] <= rom_wdata;
            log_addr.push_back(rom_addr);
            log_data.push_back(rom_wdata);
        end
    end

    int checks   = 0;
    int failures = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Leaves rx_valid high so consecutive calls stream back-to-back.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_byte_ready byte=%h actual=%b required=1", b, rx_ready);
        end else begin
            tick();
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1 && error !== 1'b1) begin
            failures++;
            $display("FAIL wait_done_timeout actual=none required=done_or_error");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_pc = 12'hFFF;
        tick(); tick();
        checks++;
        if ({rx_ready, rom_we, cpu_hold, busy, done, error} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=001000",
                     {rx_ready, rom_we, cpu_hold, busy, done, error});
        end
        checks++;
        if (rom_wdata !== 16'h0000 || rom_addr !== 12'h000) begin
            failures++;
            $display("FAIL reset_wdata_addr actual=%h/%h required=0000/000", rom_wdata, rom_addr);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (dbg_state !== 3'd0 || cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset actual=%0d/%b/%b required=0/1/0", dbg_state, cpu_hold, rx_ready);
        end
    endtask

    task automatic test_basic_load();
        log_addr.delete(); log_data.delete();
        exp_q = '{16'h1234, 16'hABCD};
        pulse_start();
        checks++;
        if ({busy, rx_ready, cpu_hold, done} !== 4'b1110) begin
            failures++;
            $display("FAIL start_flags actual=%b required=1110", {busy, rx_ready, cpu_hold, done});
        end
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        // Now in the last WRITE cycle.
        checks++;
        if (rom_we !== 1'b1 || cpu_hold !== 1'b1 || rom_addr !== 12'h001) begin
            failures++;
            $display("FAIL last_write_cycle actual=%b/%b/%h required=1/1/001", rom_we, cpu_hold, rom_addr);
        end
        tick();
        rx_valid = 1'b0;
        checks++;
        if ({done, busy, cpu_hold, rom_we, error} !== 5'b10000) begin
            failures++;
            $display("FAIL basic_done_flags actual=%b required=10000", {done, busy, cpu_hold, rom_we, error});
        end
        checks++;
        if (log_addr.size() != 2) begin
            failures++;
            $display("FAIL basic_write_count actual=%0d required=2", log_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (log_addr[i] !== 12'(i) || log_data[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL basic_write%0d actual=%h:%h required=%h:%h",
                             i, log_addr[i], log_data[i], 12'(i), exp_q[i]);
                end
            end
        end
        cpu_pc = 12'h5A3;
        #1;
        checks++;
        if (rom_addr !== 12'h5A3) begin
            failures++;
            $display("FAIL addr_follows_pc actual=%h required=5a3", rom_addr);
        end
    endtask

    task automatic test_bad_length();
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        rx_valid = 1'b0;
        checks++;
        if ({error, busy, cpu_hold, done} !== 4'b1010) begin
            failures++;
            $display("FAIL len_zero_err actual=%b required=1010", {error, busy, cpu_hold, done});
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_exit_on_start actual=%b/%b required=0/1", error, busy);
        end
        send_byte(8'h80); send_byte(8'h01);
        rx_valid = 1'b0;
        checks++;
        if ({error, busy, cpu_hold} !== 3'b101) begin
            failures++;
            $display("FAIL len_8001_err actual=%b required=101", {error, busy, cpu_hold});
        end
        pulse_start();
        send_byte(8'h10); send_byte(8'h01);
        rx_valid = 1'b0;
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL len_depth_plus1_err actual=%b required=1", error);
        end
        tick(); tick();
        checks++;
        if (log_addr.size() != 0) begin
            failures++;
            $display("FAIL bad_len_no_write actual=%0d required=0", log_addr.size());
        end
    endtask

    task automatic test_timeout();
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56);
        rx_valid = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early actual=%b/%b required=0/1", error, busy);
        end
        tick();
        checks++;
        if ({error, busy, cpu_hold} !== 3'b101) begin
            failures++;
            $display("FAIL timeout_err actual=%b required=101", {error, busy, cpu_hold});
        end
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 12'h000 || log_data[0] !== 16'h1234) begin
            failures++;
            $display("FAIL timeout_writes actual=%0d required=1 word 000:1234", log_addr.size());
        end
    endtask

    task automatic test_start_ignored();
        log_addr.delete(); log_data.delete();
        exp_q = '{16'h1111, 16'h2222};
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h11);
        rx_valid = 1'b0;
        pulse_start();   // lands in WRITE, must be ignored
        checks++;
        if (dbg_state !== 3'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_ignored_state actual=%0d/%b required=3/1", dbg_state, busy);
        end
        send_byte(8'h22); send_byte(8'h22);
        rx_valid = 1'b0;
        wait_done(10);
        checks++;
        if (done !== 1'b1 || log_addr.size() != 2) begin
            failures++;
            $display("FAIL start_ignored_done actual=%b/%0d required=1/2", done, log_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (log_addr[i] !== 12'(i) || log_data[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL ignored_write%0d actual=%h:%h required=%h:%h",
                             i, log_addr[i], log_data[i], 12'(i), exp_q[i]);
                end
            end
        end
        // Restart from DONE.
        log_addr.delete(); log_data.delete();
        pulse_start();
        checks++;
        if ({cpu_hold, done, busy} !== 3'b101) begin
            failures++;
            $display("FAIL restart_flags actual=%b required=101", {cpu_hold, done, busy});
        end
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF);
        rx_valid = 1'b0;
        wait_done(10);
        checks++;
        if (done !== 1'b1 || log_addr.size() != 1 || log_addr[0] !== 12'h000 || log_data[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL restart_write actual=%b/%0d required=1/1 word 000:beef", done, log_addr.size());
        end
    endtask

    task automatic test_reset_mid_load();
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'hAA);
        checks++;
        if (dbg_state !== 3'd4) begin
            failures++;
            $display("FAIL in_data_lo actual=%0d required=4", dbg_state);
        end
        rx_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({rx_ready, rom_we, cpu_hold, busy, done, error} !== 6'b001000 ||
            rom_wdata !== 16'h0000 || rom_addr !== 12'h000 || dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL mid_load_reset actual=%b/%h/%h/%0d required=001000/0000/000/0",
                     {rx_ready, rom_we, cpu_hold, busy, done, error}, rom_wdata, rom_addr, dbg_state);
        end
        rst_n = 1'b1;
        tick();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hC3); send_byte(8'h3C);
        rx_valid = 1'b0;
        wait_done(10);
        checks++;
        if (done !== 1'b1 || log_addr.size() != 1 || log_addr[0] !== 12'h000 || log_data[0] !== 16'hC33C) begin
            failures++;
            $display("FAIL reload_after_reset actual=%b/%0d required=1/1 word 000:c33c", done, log_addr.size());
        end
    endtask

    task automatic test_full_depth();
        logic [15:0] w;
        int mism = 0;
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h10); send_byte(8'h00);   // N = 4096 = DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            w = 16'(i) ^ 16'h5A5A;
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        rx_valid = 1'b0;
        wait_done(10);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL full_done actual=%b/%b/%b required=1/0/0", done, error, cpu_hold);
        end
        checks++;
        if (log_addr.size() != DEPTH) begin
            failures++;
            $display("FAIL full_write_count actual=%0d required=%0d", log_addr.size(), DEPTH);
        end else begin
            checks++;
            if (log_addr[DEPTH-1] !== 12'hFFF) begin
                failures++;
                $display("FAIL full_last_addr actual=%h required=fff", log_addr[DEPTH-1]);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (rom_mem[i] !== (16'(i) ^ 16'h5A5A)) mism++;
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL full_readback actual=%0d_bad_words required=0", mism);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_load();
        test_bad_length();
        test_timeout();
        test_start_ignored();
        test_reset_mid_load();
        test_full_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_boot_loader.md
Name: rom_boot_loader

Overview:
- Sequences the 32K x 16 instruction ROM at power-up and on demand.
- Receives a program image as a byte stream (valid/ready), assembles big-endian 16-bit words and writes them into the ROM write port at consecutive addresses from 0.
- Holds the CPU in reset while loading, then hands the ROM address port back to the CPU program counter.
- Replaces the hardcoded initialise-trigger program load.

Parameters:
- ADDR_W, 15, ROM address width
- DEPTH, 32768, ROM depth in words; maximum legal image length
- TIMEOUT, 1000000, clk cycles allowed between accepted bytes before a load aborts

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins a load
- rx_data  in  8  image byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- cpu_pc  in  ADDR_W  CPU fetch address
- rom_addr  out  ADDR_W  address to ROM; muxed between cpu_pc and write pointer
- rom_we  out  1  ROM write strobe
- rom_wdata  out  16  ROM write data
- cpu_hold  out  1  high = CPU held in reset
- busy  out  1  load in progress
- done  out  1  image fully written; CPU running
- error  out  1  load aborted

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; cpu_hold=1; rx_ready=0; rom_we=0; rom_wdata=0; busy=0; done=0; error=0.
  - Write pointer, length and timeout counter are cleared.
  - Reset mid-load aborts immediately. Already-written ROM words are not cleared.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
- Byte handshake:
  - A byte transfers on any edge with rx_valid and rx_ready both high.
  - rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
  - rx_ready is a registered state decode and does not depend on rx_valid.
- IDLE: start moves to LEN_HI, sets busy=1 and cpu_hold=1.
- LEN_HI / LEN_LO: capture length N, big-endian.
  - On the LEN_LO transfer, N==0 or N>DEPTH goes to ERR; otherwise go to DATA_HI with wr_ptr=0.
- DATA_HI / DATA_LO: capture the word, high byte first. The DATA_LO transfer moves to WRITE.
- WRITE: exactly one cycle.
  - rom_we=1, rom_addr=wr_ptr, rom_wdata=assembled word.
  - If wr_ptr==N-1, go to DONE; otherwise increment wr_ptr and go to DATA_HI.
  - Throughput is therefore at most one word per 3 cycles.
- DONE:
  - busy=0, done=1.
  - cpu_hold falls on the cycle after the last WRITE.
  - start restarts the load (done=0, cpu_hold=1, go to LEN_HI).
- ERR:
  - error=1, busy=0, cpu_hold=1.
  - Only start leaves ERR: it clears error and goes to LEN_HI.
- start is ignored while busy=1.
- Timeout:
  - The counter increments each cycle in LEN_* and DATA_* states without a transfer.
  - It clears on every transfer and on entering these states.
  - Reaching TIMEOUT-1 with no transfer goes to ERR on the next edge.
  - Counter width is $clog2(TIMEOUT+1).
- rom_addr mux (combinational):
  - cpu_pc when cpu_hold=0, else the write pointer.
  - The ROM read latency of 1 cycle is unchanged for the CPU.
- Width rules:
  - N is held in 16 bits, so DEPTH=32768 is legal and 32769 and above are rejected.
  - wr_ptr is ADDR_W bits and never wraps, because N<=DEPTH.

Decomposition:
- Shared package boot_pkg:
  - state enum (3-bit encoding: IDLE=0 … ERR=7)
  - ROM_ADDR_W=15, ROM_DEPTH=32768
  - WORD_W=16, BYTE_W=8
- One natural sub-module: boot_timeout_ctr (load-clear, enable, terminal-count flag), so the timeout logic is verified alone.

Test Plan:
- Reset then start, stream 00 02 12 34 AB CD with rx_valid held high -> writes [0]=0x1234 then [1]=0xABCD, one rom_we cycle each; done=1; cpu_hold falls; rom_addr follows cpu_pc.
- Length bytes 00 00 and, separately, 80 01 -> error=1 after the LEN_LO transfer, rom_we never asserted, cpu_hold=1.
- Image length 3 with rx_valid dropped for TIMEOUT cycles after the 5th byte (TIMEOUT=16 in the bench) -> error=1 exactly at count 16; [0]=written, [1] not written.
- start pulsed mid-load -> ignored, the load completes normally. start in DONE -> cpu_hold=1 and a new load at address 0.
- rst_n low during DATA_LO -> all outputs at their reset values on the next edge, then a clean reload succeeds.
- Full DEPTH image (N=32768, pattern word=addr^0x5A5A) -> last write at address 0x7FFF, done=1; ROM readback matches all words.
